// File: rtl/divmod_seq.sv
// divmod_seq: sequential unsigned restoring divider.
//
// Given dividend D and divisor S, it produces quotient Q and remainder R with
// D = Q*S + R and R < S. One quotient bit is resolved per clock, MSB first.
// Dividing by zero yields Q = all ones, R = D, div_by_zero = 1.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     dividend/divisor presented
//   in_ready     block is idle and can accept an operation
//   dividend     unsigned dividend D
//   divisor      unsigned divisor S
//   out_valid    result available (held until out_ready)
//   out_ready    consumer accepts result
//   quotient     Q, held after the output handshake
//   remainder    R, held after the output handshake
//   div_by_zero  set alongside the result when S == 0
//   busy         high while an operation is running or its result is pending
module divmod_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] dvd_r;        // dividend, shifted left as bits are consumed
    logic [WIDTH-1:0] dvs_r;        // captured divisor
    logic [WIDTH:0]   rem_r;        // partial remainder (one guard bit)
    logic [WIDTH-1:0] quo_r;        // quotient bits collected so far
    logic [CW-1:0]    cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    logic [WIDTH:0]   rem_shift_s;
    logic             rem_ge_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic             rem_top_unused_s;

    // The partial remainder is always below S after a step, so its guard bit
    // never reaches the next shift; it only exists to make the compare safe.
    assign rem_top_unused_s = rem_r[WIDTH];

    assign in_ready    = (state_r == IDLE);
    assign busy        = !in_ready;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, dvs_r});
        if (rem_ge_s) begin
            rem_next_s = rem_shift_s - {1'b0, dvs_r};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quo_next_s = {quo_r[WIDTH-2:0], rem_ge_s};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            dvd_r         <= '0;
            dvs_r         <= '0;
            rem_r         <= '0;
            quo_r         <= '0;
            cnt_r         <= CNT_ZERO;
            out_valid_r   <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                        rem_r <= '0;
                        quo_r <= '0;
                        cnt_r <= CNT_LAST;
                        if (divisor != '0) begin
                            state_r <= RUN;
                        end else begin
                            state_r <= DONE;
                        end
                    end
                end
                RUN: begin
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (cnt_r == CNT_ZERO) begin
                        state_r       <= DONE;
                        out_valid_r   <= 1'b1;
                        quotient_r    <= quo_next_s;
                        remainder_r   <= rem_next_s[WIDTH-1:0];
                        div_by_zero_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_valid_r) begin
                        if (out_ready) begin
                            out_valid_r <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end else begin
                        // Only the divide-by-zero path enters DONE without a
                        // result; publish it one edge after the accept.
                        out_valid_r   <= 1'b1;
                        quotient_r    <= '1;
                        remainder_r   <= dvd_r;
                        div_by_zero_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_seq.sv
module tb_divmod_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    divmod_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input int d, input int s, output int q, output int r, output int z);
        if (s == 0) begin
            q = (1 << W) - 1;
            r = d;
            z = 1;
        end else begin
            q = d / s;
            r = d % s;
            z = 0;
        end
    endtask

    // Present operands and return #1 after the accepting edge.
    task automatic accept(input int d, input int s);
        int n;
        dividend = d[W-1:0];
        divisor  = s[W-1:0];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
    endtask

    // Count edges from accept until out_valid; optionally churn the operands.
    task automatic wait_result(input bit churn, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (churn) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
        end
    endtask

    task automatic check_result(input string tag, input int d, input int s, input int lat);
        int q, r, z;
        model(d, s, q, r, z);
        chk({tag, "_latency"}, lat, (s == 0) ? 1 : W);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_q"}, int'(quotient), q);
        chk({tag, "_r"}, int'(remainder), r);
        chk({tag, "_dbz"}, int'(div_by_zero), z);
        if (s != 0) begin
            chk({tag, "_identity"}, int'(quotient) * s + int'(remainder), d);
        end
    endtask

    // Hold out_ready low for 'hold' cycles, then complete the handshake.
    task automatic drain(input string tag, input int d, input int s, input int hold);
        int q, r, z;
        model(d, s, q, r, z);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_q"}, int'(quotient), q);
            chk({tag, "_hold_r"}, int'(remainder), r);
            chk({tag, "_hold_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_hs_valid"}, int'(out_valid), 0);
        chk({tag, "_hs_in_ready"}, int'(in_ready), 1);
        chk({tag, "_hs_q_held"}, int'(quotient), q);
        chk({tag, "_hs_r_held"}, int'(remainder), r);
        chk({tag, "_hs_dbz_held"}, int'(div_by_zero), z);
    endtask

    task automatic run_op(input string tag, input int d, input int s, input bit churn, input int hold);
        int lat;
        out_ready = (hold == 0);
        accept(d, s);
        wait_result(churn, lat);
        check_result(tag, d, s, lat);
        drain(tag, d, s, hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int d, s;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic division
        run_op("d13s3", 13, 3, 1'b0, 0);

        // Round trip from the mult/add path: 2*3+1
        run_op("rt7s3", 2 * 3 + 1, 3, 1'b0, 0);
        run_op("d15s1", 15, 1, 1'b0, 0);
        run_op("d5s9", 5, 9, 1'b0, 0);
        run_op("d15s15", 15, 15, 1'b0, 0);
        run_op("d0s5", 0, 5, 1'b0, 0);

        // Divide by zero, then a normal op clears the flag
        run_op("d7s0", 7, 0, 1'b0, 0);
        run_op("d8s2", 8, 2, 1'b0, 0);

        // Backpressure with a pending request that must wait
        out_ready = 1'b0;
        accept(10, 4);
        wait_result(1'b0, lat);
        check_result("bp10s4", 10, 4, lat);
        dividend = 4'd1;
        divisor  = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_q", int'(quotient), 2);
            chk("bp_r", int'(remainder), 2);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", int'(out_valid), 0);
        chk("bp_no_bypass", int'(in_ready), 1);
        @(posedge clk); #1;
        chk("bp_next_accepted", int'(busy), 1);
        in_valid = 1'b0;
        wait_result(1'b0, lat);
        check_result("bp_next", 1, 1, lat);
        drain("bp_next", 1, 1, 0);

        // Operand churn during RUN
        run_op("churn9s2", 9, 2, 1'b1, 0);

        // Asynchronous reset mid-RUN
        accept(14, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_q", int'(quotient), 0);
        chk("mid_rst_r", int'(remainder), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle_valid", int'(out_valid), 0);
        run_op("d14s3", 14, 3, 1'b0, 0);

        // Boundary operands
        run_op("d15s14", 15, 14, 1'b0, 1);
        run_op("d14s15", 14, 15, 1'b0, 2);

        // Randomized operations with random backpressure
        for (int k = 0; k < 40; k++) begin
            d = int'($urandom_range(15, 0));
            s = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(15, 1));
            run_op("rand", d, s, 1'(($urandom_range(3, 0) == 0)), int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/divmod_seq.md
Name: divmod_seq

Overview:
- Sequential unsigned divider: the inverse of the multiply-then-add datapath.
- Given dividend D and divisor S, it returns quotient Q and remainder R such that D = Q*S + R, with R < S.
- Restoring division, one quotient bit per clock, valid/ready handshakes on both input and output.
- Sits beside the mult/add arithmetic blocks. It decomposes a combined result back into its multiplier and addend terms.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  dividend/divisor presented
in_ready  output  1  block can accept an operation
dividend  input  WIDTH  unsigned dividend D
divisor  input  WIDTH  unsigned divisor S
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  Q
remainder  output  WIDTH  R
div_by_zero  output  1  set with result when S == 0
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state IDLE; out_valid, quotient, remainder and div_by_zero all 0; internal shift/count registers 0.
- Reset asserted mid-operation aborts the operation immediately; no result is produced.
- Combinational outputs: in_ready = (state == IDLE); busy = !in_ready.
- States:
  - IDLE: on in_valid && in_ready at edge E0, capture D and S.
    - If S != 0: go to RUN; partial remainder = 0, count = WIDTH-1.
    - If S == 0: go to DONE.
  - RUN: each edge, shift the next dividend bit (MSB first) into the partial remainder (WIDTH+1 bits internally).
    - If partial remainder >= S: subtract S and shift 1 into Q; else shift 0.
    - count decrements; on the edge processing count == 0, go to DONE and register Q and R.
  - DONE: out_valid = 1. On out_valid && out_ready, go to IDLE and clear out_valid.
    - quotient, remainder and div_by_zero hold their last values after the handshake.
- Latency:
  - S != 0: out_valid is first high in the cycle after edge E0+WIDTH, i.e. WIDTH edges after the accept edge.
  - S == 0: out_valid high after edge E0+1. Result is Q = all ones, R = D, div_by_zero = 1.
- Input capture: operands are registered at accept; dividend and divisor changes afterwards are ignored. in_valid during RUN or DONE is not accepted, and the source must hold it.
- Backpressure: while out_valid && !out_ready, quotient, remainder and div_by_zero are stable and out_valid stays high indefinitely.
- No bypass: a new operation cannot be accepted on the edge that completes the output handshake. in_ready rises the cycle after, so minimum spacing is WIDTH+2 cycles per operation.
- Boundary cases:
  - D < S gives Q = 0, R = D.
  - D == 0 gives Q = 0, R = 0 (for S != 0).
  - S == 1 gives Q = D, R = 0.
  - D = S = 2^WIDTH-1 gives Q = 1, R = 0.
  - The internal remainder is WIDTH+1 bits, so the compare never overflows at D, S near 2^WIDTH-1.
- Invariant: Q*S + R == D, computed at 2*WIDTH bits, and R < S for every non-zero S.

Test Plan (WIDTH=4):
- D=13, S=3, out_ready=1 -> out_valid 4 edges after accept; Q=4, R=1, div_by_zero=0; in_ready returns 1 the cycle after the handshake.
- Round trip with the mult/add path: arg1=2, arg2=3, arg3=1 gives 7; feed D=7, S=3 -> Q=2, R=1. Also D=15, S=1 -> Q=15, R=0; D=5, S=9 -> Q=0, R=5; D=15, S=15 -> Q=1, R=0.
- D=7, S=0 -> out_valid 1 edge after accept; Q=15, R=7, div_by_zero=1; the next op D=8, S=2 yields div_by_zero=0, Q=4, R=0.
- Backpressure: D=10, S=4 with out_ready=0 for 6 cycles -> out_valid, Q=2, R=2 held stable. in_valid with D=1, S=1 asserted meanwhile is not accepted (in_ready=0). Release out_ready -> that operation is accepted the cycle after the handshake and returns Q=1, R=0.
- Operand churn: accept D=9, S=2, then change dividend/divisor every cycle during RUN -> result Q=4, R=1 unaffected.
- Reset mid-RUN: assert rst 2 cycles after accepting D=14, S=3 -> out_valid=0, quotient=0, remainder=0, in_ready=1 immediately (asynchronous). After release, D=14, S=3 -> Q=4, R=2.
